// File: rtl/life_grid_controller_if.sv
// life_grid_controller_if
//   Bundles the command, pattern-write, evolution-stage and status signals
//   of the life grid controller so the controller takes a single bus port.
//
//   Signals (direction seen from the controller / slave side):
//     cmd_run     in   level, free-run generations while high
//     cmd_step    in   pulse, run exactly one generation
//     cmd_clear   in   pulse, zero the grid and generation count
//     period      in   clocks between generation starts in run mode
//     wr_en       in   cell write strobe
//     wr_row      in   cell row index
//     wr_col      in   cell column index
//     wr_data     in   cell value
//     evo_next    in   evolution stage result
//     evo_finish  in   evolution stage done flag
//     grid        out  current grid, drives the evolution stage prev
//     wr_ready    out  high when a write will be accepted
//     busy        out  high while a generation is in flight
//     gen_count   out  generations completed, saturating
interface life_grid_controller_if #(
    parameter int P_PARAM_N    = 5,
    parameter int P_TICK_WIDTH = 24
);
    logic                               cmd_run;
    logic                               cmd_step;
    logic                               cmd_clear;
    logic [P_TICK_WIDTH-1:0]            period;
    logic                               wr_en;
    logic [7:0]                         wr_row;
    logic [7:0]                         wr_col;
    logic [1:0]                         wr_data;
    logic [P_PARAM_N*P_PARAM_N*2-1:0]   evo_next;
    logic                               evo_finish;
    logic [P_PARAM_N*P_PARAM_N*2-1:0]   grid;
    logic                               wr_ready;
    logic                               busy;
    logic [15:0]                        gen_count;

    modport master (
        output cmd_run, cmd_step, cmd_clear, period,
        output wr_en, wr_row, wr_col, wr_data,
        output evo_next, evo_finish,
        input  grid, wr_ready, busy, gen_count
    );

    modport slave (
        input  cmd_run, cmd_step, cmd_clear, period,
        input  wr_en, wr_row, wr_col, wr_data,
        input  evo_next, evo_finish,
        output grid, wr_ready, busy, gen_count
    );
endinterface

// File: rtl/life_grid_controller.sv
// life_grid_controller
//   Owns the packed cell grid, feeds it to the evolution stage as prev and
//   captures the stage's next result back. Sequences generations in
//   free-run (programmable period), single-step or paused mode, and accepts
//   per-cell pattern writes and a whole-grid clear while idle.
//
//   Ports:
//     clk   system clock
//     rst   synchronous, active-high reset
//     bus   life_grid_controller_if.slave (commands, cell writes,
//           evolution stage handshake, grid/status outputs)
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | paused; accepts clear, cell writes, step and run
//   S_TICK    | run mode, counting out the generation period
//   S_ISSUE   | generation launched, grid frozen for the evolution stage
//   S_WAIT    | waiting out the stage latency and evo_finish
//   S_CAPTURE | evo_next loaded into the grid, generation counted
module life_grid_controller #(
    parameter int P_PARAM_N     = 5,
    parameter int P_TICK_WIDTH  = 24,
    parameter int P_EVO_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    life_grid_controller_if.slave bus
);

    localparam int GW  = P_PARAM_N * P_PARAM_N * 2;
    localparam int TW1 = P_TICK_WIDTH + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TICK    = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;

    localparam logic [7:0] LAT_LAST = 8'(P_EVO_LATENCY);

    logic [2:0]              state_q, state_d;
    logic [P_TICK_WIDTH-1:0] tick_q, tick_d;
    logic [7:0]              lat_q, lat_d;
    logic [GW-1:0]           grid_q, grid_d;
    logic                    step_q, step_d;
    logic [15:0]             gen_count_q;

    // One extra bit so counter+1 never wraps before the compare.
    logic [TW1-1:0]          period_eff;
    logic [TW1-1:0]          tick_next;

    always_comb begin
        period_eff = (bus.period == '0) ? TW1'(1) : {1'b0, bus.period};
        tick_next  = {1'b0, tick_q} + TW1'(1);
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        lat_d   = lat_q;
        grid_d  = grid_q;
        step_d  = step_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_clear) begin
                    grid_d = '0;
                end else if (bus.wr_en) begin
                    // Out-of-range indices match no cell and are dropped.
                    for (int i = 0; i < P_PARAM_N; i++) begin
                        for (int j = 0; j < P_PARAM_N; j++) begin
                            if (bus.wr_row == 8'(i) && bus.wr_col == 8'(j)) begin
                                grid_d[(i*P_PARAM_N+j)*2 +: 2] = bus.wr_data;
                            end
                        end
                    end
                end else if (bus.cmd_step) begin
                    state_d = S_ISSUE;
                    step_d  = 1'b1;
                    lat_d   = '0;
                end else if (bus.cmd_run) begin
                    state_d = S_TICK;
                    tick_d  = '0;
                    step_d  = 1'b0;
                end
            end
            S_TICK: begin
                if (!bus.cmd_run) begin
                    state_d = S_IDLE;
                end else if (tick_next >= period_eff) begin
                    state_d = S_ISSUE;
                    lat_d   = '0;
                end else begin
                    tick_d = tick_next[P_TICK_WIDTH-1:0];
                end
            end
            S_ISSUE: begin
                lat_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Counter parks at its last value while evo_finish stalls.
                if (lat_q + 8'd1 >= LAT_LAST) begin
                    if (bus.evo_finish) begin
                        state_d = S_CAPTURE;
                    end
                end else begin
                    lat_d = lat_q + 8'd1;
                end
            end
            S_CAPTURE: begin
                grid_d = bus.evo_next;
                if (!step_q && bus.cmd_run) begin
                    state_d = S_TICK;
                    tick_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            lat_q   <= '0;
            grid_q  <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            lat_q   <= lat_d;
            grid_q  <= grid_d;
            step_q  <= step_d;
        end
    end

    // Count is only touched on clear or capture, so it otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            gen_count_q <= '0;
        end else if (state_q == S_IDLE && bus.cmd_clear) begin
            gen_count_q <= '0;
        end else if (state_q == S_CAPTURE && gen_count_q != 16'hFFFF) begin
            gen_count_q <= gen_count_q + 16'd1;
        end
    end

    assign bus.grid      = grid_q;
    assign bus.gen_count = gen_count_q;
    assign bus.busy      = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                           (state_q == S_CAPTURE);
    assign bus.wr_ready  = (state_q == S_IDLE);

endmodule
